// File: rtl/nor_32bit.sv
// Registered bitwise NOR unit for the ALU datapath: res = ~(a | b), one-cycle latency.
// Define NOR32_POPCNT_EN to add the ones_cnt popcount output.
module nor_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones
`ifdef NOR32_POPCNT_EN
    ,
    output logic [6:0]       ones_cnt
`endif
);

    logic [WIDTH-1:0] nor_vec;
    logic             zero_next;
    logic             all_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign nor_vec[i] = ~(a[i] | b[i]);
    end

    assign zero_next = ~|nor_vec;
    assign all_next  = &nor_vec;

`ifdef NOR32_POPCNT_EN
    // Heap-indexed adder tree: node k sums children 2k and 2k+1, leaves at 64..127.
    localparam int LEAVES = 64;

    logic [6:0] node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < WIDTH) begin : g_used
            assign node[LEAVES+i] = {6'd0, nor_vec[i]};
        end else begin : g_pad
            assign node[LEAVES+i] = 7'd0;
        end
    end

    for (genvar k = 1; k < LEAVES; k++) begin : g_sum
        assign node[k] = node[2*k] + node[2*k+1];
    end
`endif

    // Result and flags only load on a valid capture, so idle inputs never leak through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b1;
            all_ones  <= 1'b0;
`ifdef NOR32_POPCNT_EN
            ones_cnt  <= 7'd0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res      <= nor_vec;
                zero     <= zero_next;
                all_ones <= all_next;
`ifdef NOR32_POPCNT_EN
                ones_cnt <= node[1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_nor_32bit.sv
// Self-checking bench for nor_32bit: directed table, reset corners, pipeline
// hold behaviour and randomized vectors against a behavioural model.
module tb_nor_32bit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         out_valid;
    logic         zero;
    logic         all_ones;
`ifdef NOR32_POPCNT_EN
    logic [6:0]   ones_cnt;
`endif

    nor_32bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .res       (res),
        .out_valid (out_valid),
        .zero      (zero),
        .all_ones  (all_ones)
`ifdef NOR32_POPCNT_EN
        ,
        .ones_cnt  (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model of the visible output state
    logic [W-1:0] m_res;
    logic         m_valid;
    logic         m_zero;
    logic         m_all;
    int           m_cnt;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         all;
        int           cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_res   = '0;
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_all   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".res"}, 64'(res), 64'(m_res));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".zero"}, 64'(zero), 64'(m_zero));
        chk({tag, ".all_ones"}, 64'(all_ones), 64'(m_all));
`ifdef NOR32_POPCNT_EN
        chk({tag, ".ones_cnt"}, 64'(ones_cnt), 64'(m_cnt));
`endif
    endtask

    // Check outputs from the previous edge, then present a new input cycle.
    task automatic step(input string tag, input logic v,
                        input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        check_model(tag);
        in_valid = v;
        a        = va;
        b        = vb;
        m_valid  = v;
        if (v) begin
            m_res  = ~(va | vb);
            m_zero = (m_res == '0);
            m_all  = (va == '0) && (vb == '0);
            m_cnt  = $countones(m_res);
        end
    endtask

    initial begin
        tbl[0] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0};
        tbl[2] = '{32'h0003FFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0};
        tbl[3] = '{32'h0003FFFF, 32'h00000000, 32'hFFFC0000, 1'b0, 1'b0, 14};
        tbl[4] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32};
        tbl[5] = '{32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0, 0};
        tbl[6] = '{32'hFFFFFFFE, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1};
        tbl[7] = '{32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1};

        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("reset");
        reset = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            step($sformatf("tbl%0d.pre", i), 1'b1, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.res", i), 64'(res), 64'(tbl[i].res));
            chk($sformatf("tbl%0d.zero", i), 64'(zero), 64'(tbl[i].zero));
            chk($sformatf("tbl%0d.all_ones", i), 64'(all_ones), 64'(tbl[i].all));
            chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'd1);
`ifdef NOR32_POPCNT_EN
            chk($sformatf("tbl%0d.ones_cnt", i), 64'(ones_cnt), 64'(tbl[i].cnt));
`endif
        end

        // Back-to-back, then idle with garbage inputs: outputs must hold
        for (int i = 0; i < 4; i++)
            step("b2b", 1'b1, W'($urandom), W'($urandom));
        for (int i = 0; i < 3; i++)
            step("idle", 1'b0, 'x, 'x);
        step("resume", 1'b1, 32'h0000FFFF, 32'h00FF0000);
        step("after", 1'b0, '0, '0);

        // Reset asserted between edges must clear outputs immediately
        step("pre_rst", 1'b1, 32'h00000000, 32'h00000000);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        step("post_rst", 1'b1, 32'h12345678, 32'h0F0F0F0F);

        // Randomized traffic
        for (int i = 0; i < 1000; i++)
            step("rand", ($urandom_range(0, 9) < 8), W'($urandom), W'($urandom));
        @(negedge clk);
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
